// File: rtl/mem_arbiter.sv
// Two-port (DMA over CPU, fixed priority) arbiter in front of the main memory block.
// Optional nonexistent-memory timeout is built with `define NXM_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned WORD_W = 36
`ifdef NXM_TIMEOUT_EN
  , parameter int unsigned NXM_CYCLES = 16
`endif
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // CPU port
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_write_data_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  output logic [WORD_W-1:0] cpu_read_data_o,
  output logic              cpu_read_ack_o,
  output logic              cpu_write_ack_o,
  output logic              cpu_nxm_o,
  // DMA/IO port
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [WORD_W-1:0] dma_write_data_i,
  input  logic              dma_read_i,
  input  logic              dma_write_i,
  output logic [WORD_W-1:0] dma_read_data_o,
  output logic              dma_read_ack_o,
  output logic              dma_write_ack_o,
  output logic              dma_nxm_o,
  // memory port
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_write_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [WORD_W-1:0] mem_read_data_i,
  input  logic              read_ack_i,
  input  logic              write_ack_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q;
  logic                grant_dma_q;
  logic                op_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [WORD_W-1:0]   cpu_rdata_q;
  logic [WORD_W-1:0]   dma_rdata_q;
  logic                cpu_read_ack_q;
  logic                cpu_write_ack_q;
  logic                dma_read_ack_q;
  logic                dma_write_ack_q;

  logic dma_req;
  logic cpu_req;
  logic ack_match;

  assign dma_req   = dma_read_i | dma_write_i;
  assign cpu_req   = cpu_read_i | cpu_write_i;
  // Only the ack matching the strobe in flight completes the access.
  assign ack_match = op_write_q ? write_ack_i : read_ack_i;

`ifdef NXM_TIMEOUT_EN
  localparam logic [7:0] NXM_LAST = 8'(NXM_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       cpu_nxm_q;
  logic       dma_nxm_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      grant_dma_q     <= 1'b0;
      op_write_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      cpu_rdata_q     <= '0;
      dma_rdata_q     <= '0;
      cpu_read_ack_q  <= 1'b0;
      cpu_write_ack_q <= 1'b0;
      dma_read_ack_q  <= 1'b0;
      dma_write_ack_q <= 1'b0;
`ifdef NXM_TIMEOUT_EN
      cnt_q           <= '0;
      cpu_nxm_q       <= 1'b0;
      dma_nxm_q       <= 1'b0;
`endif
    end else begin
      // Ack and nxm are single-cycle pulses raised only on the edge into DONE.
      cpu_read_ack_q  <= 1'b0;
      cpu_write_ack_q <= 1'b0;
      dma_read_ack_q  <= 1'b0;
      dma_write_ack_q <= 1'b0;
`ifdef NXM_TIMEOUT_EN
      cpu_nxm_q       <= 1'b0;
      dma_nxm_q       <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          // Read+write together on one port is performed as a write.
          if (dma_req) begin
            grant_dma_q <= 1'b1;
            op_write_q  <= dma_write_i;
            mem_addr_q  <= dma_addr_i;
            mem_wdata_q <= dma_write_data_i;
            mem_write_q <= dma_write_i;
            mem_read_q  <= ~dma_write_i;
            state_q     <= ACCESS;
`ifdef NXM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else if (cpu_req) begin
            grant_dma_q <= 1'b0;
            op_write_q  <= cpu_write_i;
            mem_addr_q  <= cpu_addr_i;
            mem_wdata_q <= cpu_write_data_i;
            mem_write_q <= cpu_write_i;
            mem_read_q  <= ~cpu_write_i;
            state_q     <= ACCESS;
`ifdef NXM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end

        ACCESS: begin
          if (ack_match) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (op_write_q) begin
              state_q <= DONE;
              if (grant_dma_q) dma_write_ack_q <= 1'b1;
              else             cpu_write_ack_q <= 1'b1;
            end else begin
              state_q <= RDATA;
            end
          end
`ifdef NXM_TIMEOUT_EN
          else if (cnt_q == NXM_LAST) begin
            // Timeout: complete with nxm; a timed-out read returns zero.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
            if (grant_dma_q) begin
              dma_nxm_q <= 1'b1;
              if (op_write_q) begin
                dma_write_ack_q <= 1'b1;
              end else begin
                dma_read_ack_q <= 1'b1;
                dma_rdata_q    <= '0;
              end
            end else begin
              cpu_nxm_q <= 1'b1;
              if (op_write_q) begin
                cpu_write_ack_q <= 1'b1;
              end else begin
                cpu_read_ack_q <= 1'b1;
                cpu_rdata_q    <= '0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end

        RDATA: begin
          state_q <= DONE;
          if (grant_dma_q) begin
            dma_rdata_q    <= mem_read_data_i;
            dma_read_ack_q <= 1'b1;
          end else begin
            cpu_rdata_q    <= mem_read_data_i;
            cpu_read_ack_q <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o       = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;

  assign cpu_read_data_o  = cpu_rdata_q;
  assign cpu_read_ack_o   = cpu_read_ack_q;
  assign cpu_write_ack_o  = cpu_write_ack_q;
  assign dma_read_data_o  = dma_rdata_q;
  assign dma_read_ack_o   = dma_read_ack_q;
  assign dma_write_ack_o  = dma_write_ack_q;

`ifdef NXM_TIMEOUT_EN
  assign cpu_nxm_o = cpu_nxm_q;
  assign dma_nxm_o = dma_nxm_q;
`else
  assign cpu_nxm_o = 1'b0;
  assign dma_nxm_o = 1'b0;
`endif

endmodule
